div_ctrl: RTL

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl_pkg.sv | 16 +
 rtl/div_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared defines for the divide controller.
//   REG_DATA_WIDTH    : architectural register width (32)
//   DOUBLE_DATA_WIDTH : divider result width, {remainder, quotient} (64)
//   divc_state_e      : controller FSM encodings DIVC_IDLE / DIVC_BUSY / DIVC_DONE
package div_ctrl_pkg;

   localparam int unsigned REG_DATA_WIDTH    = 32;
   localparam int unsigned DOUBLE_DATA_WIDTH = 64;

   typedef enum logic [1:0] {
      DIVC_IDLE = 2'd0,
      DIVC_BUSY = 2'd1,
      DIVC_DONE = 2'd2
   } divc_state_e;

endpackage

// File: rtl/div_ctrl.sv
// Divide controller sitting in EX. Accepts a DIV/DIVU from EX, stalls the front of the pipe while
// the sibling divider works, writes {remainder, quotient} to HI/LO, and aborts on flush or timeout.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   ex_div_valid, ex_div_signed     EX holds a divide; 1 = signed (DIV)
//   ex_op1, ex_op2                  dividend / divisor
//   flush_in                        pipeline flush / exception
//   stall_req_out                   hold IF/ID/EX (combinational)
//   div_start_out, div_cancel_out,
//   div_signed_out                  divider controls
//   div_dived_out, div_div_out      latched operands to the divider
//   div_res_in, div_ready_in        divider result {rem, quot} and its valid
//   hilo_we_out, hi_out, lo_out     HI/LO write port
//   div_err_out                     one-cycle timeout pulse
module div_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = 40
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         ex_div_valid,
   input  logic                         ex_div_signed,
   input  logic [REG_DATA_WIDTH-1:0]    ex_op1,
   input  logic [REG_DATA_WIDTH-1:0]    ex_op2,
   input  logic                         flush_in,
   output logic                         stall_req_out,
   output logic                         div_start_out,
   output logic                         div_cancel_out,
   output logic                         div_signed_out,
   output logic [REG_DATA_WIDTH-1:0]    div_dived_out,
   output logic [REG_DATA_WIDTH-1:0]    div_div_out,
   input  logic [DOUBLE_DATA_WIDTH-1:0] div_res_in,
   input  logic                         div_ready_in,
   output logic                         hilo_we_out,
   output logic [REG_DATA_WIDTH-1:0]    hi_out,
   output logic [REG_DATA_WIDTH-1:0]    lo_out,
   output logic                         div_err_out
);

   // Last BUSY count value before the operation is given up.
   localparam logic [5:0] BusyLast = 6'(TIMEOUT - 1);

   divc_state_e               state_q, state_d;
   logic [5:0]                busy_cnt_q, busy_cnt_d;
   logic                      start_q, start_d;
   logic                      cancel_q, cancel_d;
   logic                      signed_q, signed_d;
   logic [REG_DATA_WIDTH-1:0] dived_q, dived_d;
   logic [REG_DATA_WIDTH-1:0] div_q, div_d;
   logic                      hilo_we_q, hilo_we_d;
   logic [REG_DATA_WIDTH-1:0] hi_q, hi_d;
   logic [REG_DATA_WIDTH-1:0] lo_q, lo_d;
   logic                      err_q, err_d;

   always_comb begin
      // Pulses default low so they can never last more than one cycle.
      state_d    = state_q;
      busy_cnt_d = busy_cnt_q;
      start_d    = start_q;
      cancel_d   = 1'b0;
      signed_d   = signed_q;
      dived_d    = dived_q;
      div_d      = div_q;
      hilo_we_d  = 1'b0;
      hi_d       = hi_q;
      lo_d       = lo_q;
      err_d      = 1'b0;

      unique case (state_q)
         DIVC_IDLE: begin
            if (ex_div_valid && !flush_in) begin
               dived_d    = ex_op1;
               div_d      = ex_op2;
               signed_d   = ex_div_signed;
               start_d    = 1'b1;
               busy_cnt_d = '0;
               state_d    = DIVC_BUSY;
            end
         end
         DIVC_BUSY: begin
            busy_cnt_d = busy_cnt_q + 6'd1;
            // Flush beats a result arriving in the same cycle.
            if (flush_in) begin
               cancel_d = 1'b1;
               start_d  = 1'b0;
               state_d  = DIVC_IDLE;
            end else if (div_ready_in) begin
               hi_d      = div_res_in[DOUBLE_DATA_WIDTH-1:REG_DATA_WIDTH];
               lo_d      = div_res_in[REG_DATA_WIDTH-1:0];
               hilo_we_d = 1'b1;
               start_d   = 1'b0;
               state_d   = DIVC_DONE;
            end else if (busy_cnt_q == BusyLast) begin
               cancel_d = 1'b1;
               err_d    = 1'b1;
               start_d  = 1'b0;
               state_d  = DIVC_IDLE;
            end
         end
         DIVC_DONE: begin
            // The finished divide is still sitting in EX; do not re-accept it.
            state_d = DIVC_IDLE;
         end
         default: state_d = DIVC_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= DIVC_IDLE;
         busy_cnt_q <= '0;
         start_q    <= 1'b0;
         cancel_q   <= 1'b0;
         signed_q   <= 1'b0;
         dived_q    <= '0;
         div_q      <= '0;
         hilo_we_q  <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         busy_cnt_q <= busy_cnt_d;
         start_q    <= start_d;
         cancel_q   <= cancel_d;
         signed_q   <= signed_d;
         dived_q    <= dived_d;
         div_q      <= div_d;
         hilo_we_q  <= hilo_we_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         err_q      <= err_d;
      end
   end

   // Stall in the accepting cycle too, so EX does not advance past the divide.
   assign stall_req_out = ((state_q == DIVC_IDLE) && ex_div_valid && !flush_in) ||
                          (state_q == DIVC_BUSY);

   assign div_start_out  = start_q;
   assign div_cancel_out = cancel_q;
   assign div_signed_out = signed_q;
   assign div_dived_out  = dived_q;
   assign div_div_out    = div_q;
   assign hilo_we_out    = hilo_we_q;
   assign hi_out         = hi_q;
   assign lo_out         = lo_q;
   assign div_err_out    = err_q;

endmodule
